// File: rtl/score_display_n.sv
// N-digit BCD score counter with high-score register and multiplexed 7-segment drive.
// Score/high score update on the clock edge after inc/clr/hi_clr; segments and digits are registered.
// No backpressure: inc/clr pulses are consumed every cycle, and the display scan free-runs.
module score_display_n #(
  parameter int DIGITS      = 2,
  parameter int REFRESH_DIV = 1,
  parameter int WRAP        = 1,
  parameter int BLANK_LZ    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  inc,
  input  logic                  hi_clr,
  input  logic                  show_hi,
  input  logic                  ena,
  input  logic                  invert,
  output logic [6:0]            segments,
  output logic [DIGITS-1:0]     digits,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic [4*DIGITS-1:0]   hi_bcd
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
  localparam logic [RW-1:0] LAST_REF = RW'(REFRESH_DIV - 1);

  logic [4*DIGITS-1:0] r_score;
  logic [4*DIGITS-1:0] r_hi;
  logic                r_ovf;
  logic [IW-1:0]       r_idx;
  logic [RW-1:0]       r_ref;
  logic [6:0]          r_seg;
  logic [DIGITS-1:0]   r_dig;

  logic [4*DIGITS-1:0] w_inc_score;
  logic                w_all9;
  logic [4*DIGITS-1:0] w_src;
  logic [3:0]          w_nib;
  logic                w_lz;
  logic                w_blank;
  logic [6:0]          w_seg_raw;
  logic [6:0]          w_seg;
  logic [DIGITS-1:0]   w_dig;

  // BCD +1 with ripple carry; a carry out of the top digit means the score was all 9s
  always_comb begin
    logic carry;
    carry       = 1'b1;
    w_inc_score = r_score;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (r_score[4*i +: 4] == 4'd9) begin
          w_inc_score[4*i +: 4] = 4'd0;
        end else begin
          w_inc_score[4*i +: 4] = r_score[4*i +: 4] + 4'd1;
          carry                 = 1'b0;
        end
      end
    end
    w_all9 = carry;
  end

  // Score register: clear beats increment; at all 9s either wrap (incremented value is all 0s) or hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_score <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_ovf <= 1'b0;
      if (clr) begin
        r_score <= '0;
      end else if (inc) begin
        r_ovf <= w_all9;
        if (!w_all9 || (WRAP != 0)) begin
          r_score <= w_inc_score;
        end
      end
    end
  end

  // High score tracks the registered score, so it lags one cycle; BCD compares correctly as binary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi <= '0;
    end else if (hi_clr) begin
      r_hi <= '0;
    end else if (r_score > r_hi) begin
      r_hi <= r_score;
    end
  end

  // Scan: refresh prescaler, then digit index advance with wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ref <= '0;
      r_idx <= '0;
    end else if (r_ref == LAST_REF) begin
      r_ref <= '0;
      r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IW'(1);
    end else begin
      r_ref <= r_ref + RW'(1);
    end
  end

  // Select the active digit of the shown value, decide blanking, encode and apply polarity
  always_comb begin
    logic zero_above;
    w_src      = show_hi ? r_hi : r_score;
    w_nib      = 4'd0;
    w_lz       = 1'b0;
    w_dig      = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above & (w_src[4*i +: 4] == 4'd0);
      w_dig[i]   = (r_idx == IW'(i));
      if (r_idx == IW'(i)) begin
        w_nib = w_src[4*i +: 4];
        w_lz  = zero_above && (i > 0);
      end
    end
    w_blank = !ena || ((BLANK_LZ != 0) && w_lz);
    case (w_nib)
      4'd0:    w_seg_raw = 7'b0111111;
      4'd1:    w_seg_raw = 7'b0000110;
      4'd2:    w_seg_raw = 7'b1011011;
      4'd3:    w_seg_raw = 7'b1001111;
      4'd4:    w_seg_raw = 7'b1100110;
      4'd5:    w_seg_raw = 7'b1101101;
      4'd6:    w_seg_raw = 7'b1111101;
      4'd7:    w_seg_raw = 7'b0000111;
      4'd8:    w_seg_raw = 7'b1111111;
      4'd9:    w_seg_raw = 7'b1101111;
      default: w_seg_raw = 7'b0000000;
    endcase
    w_seg = (w_blank ? 7'b0000000 : w_seg_raw) ^ {7{invert}};
    w_dig = w_dig ^ {DIGITS{invert}};
  end

  // Output pin registers; forced to 0 during reset regardless of polarity
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg <= 7'b0;
      r_dig <= '0;
    end else begin
      r_seg <= w_seg;
      r_dig <= w_dig;
    end
  end

  assign segments  = r_seg;
  assign digits    = r_dig;
  assign ovf       = r_ovf;
  assign score_bcd = r_score;
  assign hi_bcd    = r_hi;

endmodule

// File: tb/tb_score_display_n.sv
module tb_score_display_n;

  logic clk = 1'b0;
  logic rst, clr, inc, hi_clr, show_hi, ena, invert;

  logic [6:0]  seg_a, seg_b, seg_c;
  logic [1:0]  dig_a, dig_b;
  logic [2:0]  dig_c;
  logic        ovf_a, ovf_b, ovf_c;
  logic [7:0]  sc_a, sc_b, hi_a, hi_b;
  logic [11:0] sc_c, hi_c;

  always #5 clk = ~clk;

  // a: 2 digits, wrap, blanking; b: 2 digits, slow scan, saturate, no blanking; c: 3 digits
  score_display_n #(.DIGITS(2), .REFRESH_DIV(1), .WRAP(1), .BLANK_LZ(1)) u_a (
    .clk(clk), .rst(rst), .clr(clr), .inc(inc), .hi_clr(hi_clr), .show_hi(show_hi),
    .ena(ena), .invert(invert), .segments(seg_a), .digits(dig_a), .ovf(ovf_a),
    .score_bcd(sc_a), .hi_bcd(hi_a));
  score_display_n #(.DIGITS(2), .REFRESH_DIV(4), .WRAP(0), .BLANK_LZ(0)) u_b (
    .clk(clk), .rst(rst), .clr(clr), .inc(inc), .hi_clr(hi_clr), .show_hi(show_hi),
    .ena(ena), .invert(invert), .segments(seg_b), .digits(dig_b), .ovf(ovf_b),
    .score_bcd(sc_b), .hi_bcd(hi_b));
  score_display_n #(.DIGITS(3), .REFRESH_DIV(1), .WRAP(1), .BLANK_LZ(1)) u_c (
    .clk(clk), .rst(rst), .clr(clr), .inc(inc), .hi_clr(hi_clr), .show_hi(show_hi),
    .ena(ena), .invert(invert), .segments(seg_c), .digits(dig_c), .ovf(ovf_c),
    .score_bcd(sc_c), .hi_bcd(hi_c));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: decimal integers, digits extracted arithmetically
  int P_D  [3] = '{2, 2, 3};
  int P_RD [3] = '{1, 4, 1};
  int P_W  [3] = '{1, 0, 1};
  int P_BL [3] = '{1, 0, 1};
  int POW10[4] = '{1, 10, 100, 1000};
  logic [6:0] SEG_TAB[10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                              7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

  int m_score[3], m_hi[3], m_idx[3], m_ref[3];

  typedef struct {
    int         score;
    int         hi;
    logic       ovf;
    logic [6:0] seg;
    logic [2:0] dig;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    r = '0;
    for (int i = 0; i < 3; i++) r[4*i +: 4] = 4'((v / POW10[i]) % 10);
    return r;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 3; p++) begin
      m_score[p] = 0; m_hi[p] = 0; m_idx[p] = 0; m_ref[p] = 0;
    end
  endtask

  // Predict post-edge outputs from the current state and inputs, queue them, advance the model
  task automatic model_push();
    for (int p = 0; p < 3; p++) begin
      exp_t e;
      int maxv, src, nib, idx, mask;
      logic blank;
      maxv  = POW10[P_D[p]] - 1;
      idx   = m_idx[p];
      mask  = (1 << P_D[p]) - 1;
      src   = show_hi ? m_hi[p] : m_score[p];
      nib   = (src / POW10[idx]) % 10;
      blank = !ena || (P_BL[p] != 0 && idx > 0 && src < POW10[idx]);
      e.seg = blank ? 7'b0 : SEG_TAB[nib];
      if (invert) e.seg = ~e.seg;
      e.dig = 3'((invert ? ~(1 << idx) : (1 << idx)) & mask);
      e.ovf = inc && !clr && (m_score[p] == maxv);
      e.hi  = hi_clr ? 0 : ((m_score[p] > m_hi[p]) ? m_score[p] : m_hi[p]);
      if (clr) e.score = 0;
      else if (inc) e.score = (m_score[p] == maxv) ? (P_W[p] != 0 ? 0 : maxv) : m_score[p] + 1;
      else e.score = m_score[p];
      m_score[p] = e.score;
      m_hi[p]    = e.hi;
      if (m_ref[p] == P_RD[p] - 1) begin
        m_ref[p] = 0;
        m_idx[p] = (m_idx[p] + 1) % P_D[p];
      end else begin
        m_ref[p] = m_ref[p] + 1;
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic compare_pop();
    for (int p = 0; p < 3; p++) begin
      exp_t e;
      logic [11:0] o_sc, o_hi;
      logic [6:0]  o_seg;
      logic [2:0]  o_dig;
      logic        o_ovf;
      e = exp_q.pop_front();
      case (p)
        0:       begin o_sc = {4'b0, sc_a}; o_hi = {4'b0, hi_a}; o_seg = seg_a; o_dig = {1'b0, dig_a}; o_ovf = ovf_a; end
        1:       begin o_sc = {4'b0, sc_b}; o_hi = {4'b0, hi_b}; o_seg = seg_b; o_dig = {1'b0, dig_b}; o_ovf = ovf_b; end
        default: begin o_sc = sc_c; o_hi = hi_c; o_seg = seg_c; o_dig = dig_c; o_ovf = ovf_c; end
      endcase
      check($sformatf("score%0d", p), o_sc, to_bcd(e.score));
      check($sformatf("hi%0d", p), o_hi, to_bcd(e.hi));
      check($sformatf("ovf%0d", p), o_ovf, e.ovf);
      check($sformatf("seg%0d", p), o_seg, e.seg);
      check($sformatf("dig%0d", p), o_dig, e.dig);
    end
  endtask

  task automatic tick();
    model_push();
    @(posedge clk);
    #1;
    compare_pop();
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      inc = 1'b1; tick();
      inc = 1'b0; tick();
    end
  endtask

  task automatic do_clr();
    clr = 1'b1; tick();
    clr = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_seg_a"}, seg_a, 0);  check({tag, "_dig_a"}, dig_a, 0);
    check({tag, "_ovf_a"}, ovf_a, 0);  check({tag, "_sc_a"}, sc_a, 0);
    check({tag, "_hi_a"}, hi_a, 0);
    check({tag, "_seg_b"}, seg_b, 0);  check({tag, "_dig_b"}, dig_b, 0);
    check({tag, "_sc_b"}, sc_b, 0);    check({tag, "_hi_b"}, hi_b, 0);
    check({tag, "_seg_c"}, seg_c, 0);  check({tag, "_dig_c"}, dig_c, 0);
    check({tag, "_sc_c"}, sc_c, 0);    check({tag, "_hi_c"}, hi_c, 0);
    model_reset();
  endtask

  // Run until the chosen instance (0=a, 2=c) drives digit k (invert=0), then check its segments
  task automatic expect_on_digit(input string tag, input int which, input int k, input logic [6:0] exp_seg);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick();
      if (which == 0 && dig_a == 2'(1 << k)) begin
        found = 1'b1;
        check(tag, seg_a, exp_seg);
      end else if (which == 2 && dig_c == 3'(1 << k)) begin
        found = 1'b1;
        check(tag, seg_c, exp_seg);
      end
    end
    check({tag, "_seen"}, found, 1'b1);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; inc = 1'b0; hi_clr = 1'b0;
    show_hi = 1'b0; ena = 1'b1; invert = 1'b0;
    model_reset();
    #1;
    check_reset("rst0");
    @(negedge clk);
    rst = 1'b0;

    // 12 increments, scan both digits of a
    pulses(12);
    check("t1_sc_a", sc_a, 8'h12);
    expect_on_digit("t1_d0", 0, 0, 7'b1011011);
    expect_on_digit("t1_d1", 0, 1, 7'b0000110);

    // Leading-zero blanking on the 3-digit instance
    do_clr();
    pulses(5);
    expect_on_digit("t3_d2", 2, 2, 7'b0000000);
    expect_on_digit("t3_d1", 2, 1, 7'b0000000);
    expect_on_digit("t3_d0", 2, 0, 7'b1101101);
    pulses(100);
    check("t3_sc_c", sc_c, 12'h105);
    check("t3_sc_a_wrapped", sc_a, 8'h05);
    check("t3_sc_b_sat", sc_b, 8'h99);
    expect_on_digit("t3_inner0", 2, 1, 7'b0111111);

    // Wrap versus saturate at 99
    do_clr();
    pulses(99);
    check("t2_sc_a99", sc_a, 8'h99);
    inc = 1'b1; tick(); inc = 1'b0;
    check("t2_ovf_a", ovf_a, 1'b1);
    check("t2_sc_a", sc_a, 8'h00);
    check("t2_ovf_b", ovf_b, 1'b1);
    check("t2_sc_b", sc_b, 8'h99);
    check("t2_sc_c", sc_c, 12'h100);
    tick();
    check("t2_ovf_a_end", ovf_a, 1'b0);
    for (int i = 0; i < 3; i++) begin
      inc = 1'b1; tick(); inc = 1'b0;
      check("t2_ovf_b_rep", ovf_b, 1'b1);
      tick();
    end

    // High score behaviour
    hi_clr = 1'b1; clr = 1'b1; tick();
    hi_clr = 1'b0; clr = 1'b0;
    pulses(7);
    do_clr();
    check("t4_hi_a", hi_a, 8'h07);
    check("t4_sc_a", sc_a, 8'h00);
    show_hi = 1'b1;
    expect_on_digit("t4_show_hi", 0, 0, 7'b0000111);
    pulses(7);
    inc = 1'b1; tick(); inc = 1'b0;
    check("t4_sc_a8", sc_a, 8'h08);
    check("t4_hi_lag", hi_a, 8'h07);
    tick();
    check("t4_hi_a8", hi_a, 8'h08);
    clr = 1'b1; inc = 1'b1; tick(); clr = 1'b0; inc = 1'b0;
    check("t4_clr_inc", sc_a, 8'h00);
    show_hi = 1'b0;

    // Inverted polarity, display disabled, slow scan on b
    invert = 1'b1; ena = 1'b0;
    for (int i = 0; i < 17; i++) tick();
    check("t5_seg_a", seg_a, 7'h7f);
    invert = 1'b0; ena = 1'b1;

    // Asynchronous reset mid-scan at 42
    do_clr();
    pulses(42);
    tick();
    check("t6_sc_a42", sc_a, 8'h42);
    #2;
    rst = 1'b1;
    #1;
    check_reset("t6_rst");
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("t6_dig_a", dig_a, 2'b01);
    check("t6_dig_c", dig_c, 3'b001);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
